// File: rtl/odd_even_counter_pkg.sv
// Shared constants and helpers for the odd/even step-by-two counter.
package odd_even_counter_pkg;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;
    localparam int   CNT_W_DEF = 4;

    function automatic logic parity_match(input logic q_lsb, input logic mode);
        return q_lsb == mode;
    endfunction

endpackage

// File: rtl/odd_even_next.sv
// Next-count rule: step by two when Q parity matches the mode, otherwise step by
// one to land on the requested parity.
module odd_even_next
    import odd_even_counter_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic [WIDTH-1:0] q,
    input  logic             m,
    output logic [WIDTH-1:0] q_next
);

    logic             match;
    logic [WIDTH-1:0] step;

    always_comb begin
        match   = parity_match(q[0], m);
        step    = '0;
        step[1] = match;
        step[0] = !match;
        // Carry out of the MSB drops, giving the modulo-2^WIDTH wrap.
        q_next  = q + step;
    end

endmodule

// File: rtl/odd_even_counter.sv
// Step-by-two counter producing the even or odd sequence chosen by M.
// Define ODD_EVEN_COUNTER_TC_EN to add the registered terminal-count output tc.
module odd_even_counter
    import odd_even_counter_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             M,
`ifdef ODD_EVEN_COUNTER_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    odd_even_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q      (q_q),
        .m      (M),
        .q_next (q_d)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

`ifdef ODD_EVEN_COUNTER_TC_EN
    logic tc_q;
    logic tc_d;

    // Last value of the active sequence: all ones with the LSB equal to the mode.
    always_comb begin
        tc_d = (q_d == {{(WIDTH-1){1'b1}}, M});
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign tc = tc_q;
`endif

endmodule

// File: tb/tb_odd_even_counter.sv
// Bench for odd_even_counter: directed vector table followed by a random
// phase checked against an independent next-value model.
module tb_odd_even_counter;
    import odd_even_counter_pkg::*;

    localparam int W = CNT_W_DEF;

    typedef struct {
        logic         clear;
        logic         m;
        logic [W-1:0] exp_q;
    } vec_t;

    logic         clk = 1'b0;
    logic         clear;
    logic         m;
    logic [W-1:0] q;
    logic         tc;

    vec_t         vecs[$];
    logic [W:0]   exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_q;

    always #5 clk = ~clk;

    odd_even_counter #(
        .WIDTH (W)
    ) dut (
        .Clock (clk),
        .Clear (clear),
        .M     (m),
`ifdef ODD_EVEN_COUNTER_TC_EN
        .tc    (tc),
`endif
        .Q     (q)
    );

`ifndef ODD_EVEN_COUNTER_TC_EN
    assign tc = 1'b0;
`endif

    // Odd mode: round up to the next odd value; even mode: next even value above.
    function automatic logic [W-1:0] model_next(input logic c, input logic mm,
                                                input logic [W-1:0] cur);
        logic [W-1:0] one;
        logic [W-1:0] two;
        one = 1;
        two = 2;
        if (c) return '0;
        if (mm) return (cur + one) | one;
        return (cur + two) & ~one;
    endfunction

    function automatic logic model_tc(input logic c, input logic mm,
                                      input logic [W-1:0] nq);
        logic [W-1:0] last;
        last    = '1;
        last[0] = mm;
        return !c && (nq == last);
    endfunction

    function automatic void add(input logic c, input logic mm, input int eq);
        vec_t v;
        v.clear = c;
        v.m     = mm;
        v.exp_q = W'(eq);
        vecs.push_back(v);
    endfunction

    task automatic check_output();
        logic [W:0] exp;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: no expected entry for q=%0d", q);
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (q !== exp[W-1:0]) begin
            errors++;
            $display("FAIL q: got %0d expected %0d", q, exp[W-1:0]);
        end
`ifdef ODD_EVEN_COUNTER_TC_EN
        checks++;
        if (tc !== exp[W]) begin
            errors++;
            $display("FAIL tc: got %0b expected %0b (q=%0d)", tc, exp[W], q);
        end
`endif
    endtask

    task automatic drive(input logic c, input logic mm, input logic [W-1:0] eq);
        @(negedge clk);
        clear = c;
        m     = mm;
        exp_q.push_back({model_tc(c, mm, eq), eq});
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        clear = 1'b1;
        m     = MODE_EVEN;

        // Reset, count to a non-zero value, then hold Clear for 3 edges with M=1.
        add(1, MODE_EVEN, 0);
        add(0, MODE_EVEN, 2); add(0, MODE_EVEN, 4); add(0, MODE_EVEN, 6);
        add(1, MODE_ODD, 0);  add(1, MODE_ODD, 0);  add(1, MODE_ODD, 0);
        // Even run with 14 -> 0 wrap.
        for (int i = 1; i <= 9; i++) add(0, MODE_EVEN, (2 * i) % 16);
        // Odd run from reset: align to 1, wrap 15 -> 1.
        add(1, MODE_ODD, 0);
        for (int i = 0; i < 9; i++) add(0, MODE_ODD, (2 * i + 1) % 16);
        // Mode switches mid-count: 6 -> 7 and 15 -> 0.
        add(1, MODE_EVEN, 0);
        add(0, MODE_EVEN, 2); add(0, MODE_EVEN, 4); add(0, MODE_EVEN, 6);
        add(0, MODE_ODD, 7);  add(0, MODE_ODD, 9);  add(0, MODE_ODD, 11);
        add(0, MODE_ODD, 13); add(0, MODE_ODD, 15);
        add(0, MODE_EVEN, 0); add(0, MODE_EVEN, 2);
        // Clear at Q=11 for one edge, then restart the odd sequence.
        add(0, MODE_ODD, 3);  add(0, MODE_ODD, 5);  add(0, MODE_ODD, 7);
        add(0, MODE_ODD, 9);  add(0, MODE_ODD, 11);
        add(1, MODE_ODD, 0);
        add(0, MODE_ODD, 1);  add(0, MODE_ODD, 3);

        foreach (vecs[i]) drive(vecs[i].clear, vecs[i].m, vecs[i].exp_q);

        model_q = vecs[vecs.size() - 1].exp_q;
        for (int i = 0; i < 300; i++) begin
            logic c;
            logic mm;
            c       = ($urandom_range(0, 15) == 0);
            mm      = ($urandom_range(0, 3) == 0) ? ~m : m;
            model_q = model_next(c, mm, model_q);
            drive(c, mm, model_q);
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
